// File: rtl/cipher_collector.sv
// Collects one frame of ASCON cipher blocks plus its tag, then streams the
// assembled 200-byte frame (cipher bytes, then tag bytes, MSB first) over a valid/ready byte port.
module cipher_collector #(
  parameter int NB_BLOCKS = 23,
  parameter int BLOCK_W   = 64,
  parameter int TAG_W     = 128
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [BLOCK_W-1:0]           cipher_i,
  input  logic                         cipher_valid_i,
  input  logic [TAG_W-1:0]             tag_i,
  input  logic                         end_tag_i,
  output logic [7:0]                   byte_o,
  output logic                         byte_valid_o,
  input  logic                         byte_ready_i,
  output logic [NB_BLOCKS*BLOCK_W-1:0] cipher_frame_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         frame_error_o,
  output logic                         overflow_o
);

  localparam int FRAME_W      = NB_BLOCKS * BLOCK_W;
  localparam int CIPHER_BYTES = FRAME_W / 8;
  localparam int TOTAL_BYTES  = CIPHER_BYTES + TAG_W / 8;
  localparam int BLK_CNT_W    = $clog2(NB_BLOCKS + 1);
  localparam int BYTE_CNT_W   = $clog2(TOTAL_BYTES + 1);
  localparam int FRAME_IDX_W  = $clog2(FRAME_W);
  localparam int TAG_IDX_W    = $clog2(TAG_W);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]             state;
  logic [BLK_CNT_W-1:0]   blk_cnt;
  logic [BLK_CNT_W-1:0]   blk_cnt_after;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic                   cipher_valid_q;
  logic                   end_tag_q;
  logic                   cipher_evt;
  logic                   tag_evt;
  logic                   blk_room;
  logic [FRAME_IDX_W-1:0] slot_lsb;
  logic [FRAME_IDX_W-1:0] frame_byte_lsb;
  logic [TAG_IDX_W-1:0]   tag_byte_lsb;

  assign byte_valid_o = (state == SEND);
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    cipher_evt     = cipher_valid_i & ~cipher_valid_q;
    tag_evt        = end_tag_i & ~end_tag_q;
    blk_room       = (blk_cnt < BLK_CNT_W'(NB_BLOCKS));
    slot_lsb       = FRAME_IDX_W'((NB_BLOCKS - 1 - int'(blk_cnt)) * BLOCK_W);
    frame_byte_lsb = FRAME_IDX_W'(FRAME_W - 8 - 8 * int'(byte_cnt));
    tag_byte_lsb   = TAG_IDX_W'(TAG_W - 8 - 8 * (int'(byte_cnt) - CIPHER_BYTES));
    // A block captured in the same cycle as the tag still counts for the length check.
    blk_cnt_after  = (cipher_evt && blk_room) ? blk_cnt + BLK_CNT_W'(1) : blk_cnt;
    byte_o         = '0;
    if (state == SEND) begin
      if (byte_cnt < BYTE_CNT_W'(CIPHER_BYTES)) byte_o = cipher_frame_o[frame_byte_lsb +: 8];
      else                                      byte_o = tag_o[tag_byte_lsb +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      blk_cnt        <= '0;
      byte_cnt       <= '0;
      cipher_valid_q <= 1'b0;
      end_tag_q      <= 1'b0;
      cipher_frame_o <= '0;
      tag_o          <= '0;
      frame_error_o  <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      cipher_valid_q <= cipher_valid_i;
      end_tag_q      <= end_tag_i;
      case (state)
        IDLE: begin
          if (start_i) begin
            cipher_frame_o <= '0;
            tag_o          <= '0;
            blk_cnt        <= '0;
            byte_cnt       <= '0;
            frame_error_o  <= 1'b0;
            overflow_o     <= 1'b0;
            state          <= COLLECT;
          end
        end
        COLLECT: begin
          if (cipher_evt) begin
            if (blk_room) begin
              cipher_frame_o[slot_lsb +: BLOCK_W] <= cipher_i;
              blk_cnt                             <= blk_cnt_after;
            end else begin
              overflow_o <= 1'b1;
            end
          end
          if (tag_evt) begin
            tag_o         <= tag_i;
            frame_error_o <= (blk_cnt_after != BLK_CNT_W'(NB_BLOCKS));
            state         <= SEND;
          end
        end
        SEND: begin
          if (byte_ready_i) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (byte_cnt == BYTE_CNT_W'(TOTAL_BYTES - 1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_collector.sv
// Self-checking bench for cipher_collector: directed and randomized frames
// checked against a byte-list model of the expected 200-byte output.
module tb_cipher_collector;

  localparam int NB    = 23;
  localparam int TOTAL = 200;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [63:0]   cipher_i = '0;
  logic          cipher_valid_i = 1'b0;
  logic [127:0]  tag_i = '0;
  logic          end_tag_i = 1'b0;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i = 1'b0;
  logic [1471:0] cipher_frame_o;
  logic [127:0]  tag_o;
  logic          busy_o;
  logic          done_o;
  logic          frame_error_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  cipher_collector dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .cipher_i       (cipher_i),
    .cipher_valid_i (cipher_valid_i),
    .tag_i          (tag_i),
    .end_tag_i      (end_tag_i),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .byte_ready_i   (byte_ready_i),
    .cipher_frame_o (cipher_frame_o),
    .tag_o          (tag_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .frame_error_o  (frame_error_o),
    .overflow_o     (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte"},    byte_o, 0);
    check({tag, "_valid"},   byte_valid_o, 0);
    check({tag, "_frame"},   (cipher_frame_o === '0), 1);
    check({tag, "_tag"},     tag_o, 0);
    check({tag, "_busy"},    busy_o, 0);
    check({tag, "_done"},    done_o, 0);
    check({tag, "_ferr"},    frame_error_o, 0);
    check({tag, "_ovf"},     overflow_o, 0);
  endtask

  task automatic pulse_block(input logic [63:0] data, input int hold);
    cipher_i       = data;
    cipher_valid_i = 1'b1;
    repeat (hold) tick();
    cipher_valid_i = 1'b0;
    repeat ($urandom_range(1, 2)) tick();
  endtask

  // hold = 0 picks a random valid-pulse length per block; abort_at >= 0 resets mid-SEND.
  task automatic run_frame(input int n_blocks, input int hold, input int tag_hold,
                           input int ready_mode, input bit simul, input bit fixed_data,
                           input int abort_at);
    logic [63:0]   blocks[$];
    logic [7:0]    exp_bytes[$];
    logic [127:0]  tag;
    logic [1471:0] exp_frame;
    logic [63:0]   blk;
    logic [63:0]   data;
    logic [7:0]    prev_byte;
    int            captured;
    int            idx;
    int            cycles;
    int            early_done;
    bit            rdy;
    bit            prev_stall;

    tag = fixed_data ? 128'h00112233445566778899AABBCCDDEEFF
                     : {$urandom, $urandom, $urandom, $urandom};
    byte_ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_clear_frame", (cipher_frame_o === '0), 1);
    check("start_clear_ferr", frame_error_o, 0);
    check("start_clear_ovf", overflow_o, 0);

    for (int k = 0; k < n_blocks; k++) begin
      data = fixed_data ? 64'h0101010101010100 + 64'(k) : {$urandom, $urandom};
      blocks.push_back(data);
      if (simul && k == n_blocks - 1) begin
        cipher_i       = data;
        cipher_valid_i = 1'b1;
        tag_i          = tag;
        end_tag_i      = 1'b1;
        tick();
        check("simul_send_entered", byte_valid_o, 1);
        cipher_valid_i = 1'b0;
        end_tag_i      = 1'b0;
      end else begin
        pulse_block(data, (hold == 0) ? $urandom_range(1, 4) : hold);
      end
    end
    if (!simul) begin
      tag_i     = tag;
      end_tag_i = 1'b1;
      tick();
      check("tag_send_entered", byte_valid_o, 1);
      repeat (tag_hold - 1) tick();
      end_tag_i = 1'b0;
    end

    // Reference: the first NB blocks land in order, missing slots are zero.
    captured  = (n_blocks < NB) ? n_blocks : NB;
    exp_frame = '0;
    for (int s = 0; s < NB; s++) begin
      blk       = (s < captured) ? blocks[s] : 64'd0;
      exp_frame = (exp_frame << 64) | 1472'(blk);
      for (int b = 0; b < 8; b++) exp_bytes.push_back(blk[63 - 8*b -: 8]);
    end
    for (int b = 0; b < 16; b++) exp_bytes.push_back(tag[127 - 8*b -: 8]);

    idx = 0; cycles = 0; early_done = 0; prev_stall = 0; prev_byte = '0;
    while (idx < TOTAL && cycles < 4000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        reset_i = 1'b1;
        byte_ready_i = 1'b0;
        tick();
        reset_i = 1'b0;
        check_all_zero("abort");
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      byte_ready_i = rdy;
      check("send_valid", byte_valid_o, 1);
      if (prev_stall) check($sformatf("stable%0d", idx), byte_o, prev_byte);
      if (rdy) begin
        check($sformatf("byte%0d", idx), byte_o, exp_bytes[idx]);
        idx++;
      end
      prev_stall = !rdy;
      prev_byte  = byte_o;
      tick();
      cycles++;
      if (done_o && idx < TOTAL) early_done++;
    end
    byte_ready_i = 1'b0;
    check("drain_count", idx, TOTAL);
    check("early_done", early_done, 0);
    if (ready_mode == 0) check("send_cycles", cycles, TOTAL);
    check("done_pulse", done_o, 1);
    check("valid_dropped", byte_valid_o, 0);
    tick();
    check("done_once", done_o, 0);
    check("idle_busy", busy_o, 0);
    check("frame_held", (cipher_frame_o === exp_frame), 1);
    check("tag_held", tag_o, tag);
    check("frame_error", frame_error_o, (n_blocks < NB) ? 1 : 0);
    check("overflow", overflow_o, (n_blocks > NB) ? 1 : 0);
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    reset_i = 1'b0;
    tick();

    run_frame(23, 1, 1, 0, 0, 1, -1);  // nominal
    run_frame(23, 5, 3, 0, 0, 1, -1);  // long valid pulses
    run_frame(23, 1, 1, 1, 0, 0, -1);  // back-pressure 1,0,0,1
    run_frame(22, 0, 1, 2, 0, 0, -1);  // short frame
    run_frame(24, 0, 1, 0, 0, 0, -1);  // over-full frame
    run_frame(23, 1, 1, 0, 1, 0, -1);  // block 22 and tag in one cycle
    run_frame(24, 0, 2, 0, 0, 0, 50);  // abort mid-SEND with overflow set
    run_frame(23, 0, 1, 0, 0, 0, -1);  // clean frame after abort

    for (int r = 0; r < 4; r++) begin
      automatic int n = $urandom_range(21, 25);
      run_frame(n, 0, $urandom_range(1, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cipher_collector.md
Name: cipher_collector

Overview:
- Downstream neighbour of the ASCON control FSM.
- Captures the 23 ciphertext blocks (64 bit each) and the 128-bit tag as the ASCON core produces them for one ECG frame.
- Assembles them into a cipher frame and streams the 200-byte result (184 cipher bytes, then 16 tag bytes, MSB first) to the UART transmitter through a valid/ready byte interface.

Parameters:
- NB_BLOCKS, 23, number of 64-bit cipher blocks per frame.
- BLOCK_W, 64, cipher block width in bits.
- TAG_W, 128, tag width in bits.

Ports:
- clock_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse: clear buffer and arm capture of a new frame.
- cipher_i  in  64  cipher block from ASCON core.
- cipher_valid_i  in  1  cipher block valid; may stay high several cycles.
- tag_i  in  128  authentication tag.
- end_tag_i  in  1  tag valid; may stay high several cycles.
- byte_o  out  8  byte to UART TX.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  UART TX accepts byte_o this cycle.
- cipher_frame_o  out  1472  assembled cipher frame; block 0 in [1471:1408].
- tag_o  out  128  latched tag.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last byte is accepted.
- frame_error_o  out  1  sticky: tag arrived with block count not equal to NB_BLOCKS.
- overflow_o  out  1  sticky: cipher block arrived after NB_BLOCKS were captured.

Behaviour:
- Reset (synchronous, any state):
  - state = IDLE; all outputs 0, including cipher_frame_o, tag_o and both sticky flags.
  - blk_cnt = 0, byte_cnt = 0, edge-detect registers = 0.
- Edge detection:
  - Register cipher_valid_i and end_tag_i each cycle.
  - An event is input = 1 while the registered copy = 0. Exactly one capture per high pulse, whatever its length.
- States:
  - IDLE: start_i = 1 -> clear cipher_frame_o, tag_o, blk_cnt, byte_cnt, frame_error_o, overflow_o; go to COLLECT.
  - COLLECT, cipher event with blk_cnt < NB_BLOCKS: write cipher_i into slot blk_cnt (bits [1471-64*blk_cnt -: 64]); blk_cnt++. The value is visible on cipher_frame_o the next cycle.
  - COLLECT, cipher event with blk_cnt = NB_BLOCKS: data dropped; overflow_o <= 1.
  - COLLECT, end_tag event: tag_o <= tag_i; frame_error_o <= (blk_cnt != NB_BLOCKS); go to SEND.
  - COLLECT, cipher event and end_tag event in the same cycle: capture the block first (counts toward blk_cnt for the error check), then the tag; go to SEND.
  - SEND: byte_valid_o = 1 from the first SEND cycle.
    - byte_cnt 0..183: byte_o = cipher_frame_o[1471-8*byte_cnt -: 8].
    - byte_cnt 184..199: byte_o = tag_o[127-8*(byte_cnt-184) -: 8].
    - byte_o and byte_valid_o stay stable until byte_ready_i = 1.
    - On valid and ready: byte_cnt++. If byte_cnt = 199 at acceptance, go to DONE and byte_valid_o drops the next cycle.
    - byte_o comes from a combinational mux on byte_cnt.
  - DONE: done_o = 1 for exactly one cycle; go to IDLE. Buffer contents and sticky flags are held until the next start_i.
- start_i is ignored outside IDLE.
- Cipher and tag events are ignored outside COLLECT.
- byte_ready_i is ignored when byte_valid_o = 0.
- Missing blocks remain zero in the frame and are still sent; the frame is always 200 bytes.
- Reset mid-SEND aborts the frame; no done_o is produced.
- Throughput: 1 byte per cycle when byte_ready_i is held high. SEND lasts 200 cycles; end_tag event to done_o is 201 cycles.

Test Plan:
- Nominal frame: start_i; 23 one-cycle cipher pulses with block k = 64'h0101010101010100 + k; end_tag_i with tag_i = 128'h00112233445566778899AABBCCDDEEFF; byte_ready_i = 1 -> 200 bytes. First bytes 01,01,01,01,01,01,01,00; byte 183 = 16; last 16 bytes = 00..FF tag. done_o pulses once; frame_error_o = 0, overflow_o = 0.
- Long valid pulses: cipher_valid_i held 5 cycles per block, end_tag_i held 3 cycles -> exactly 23 captures and 1 tag capture; output identical to the nominal case.
- Back-pressure: byte_ready_i toggles 1,0,0,1 repeatedly -> byte_o stable while not ready; no byte skipped or duplicated; done_o after byte 199 is accepted.
- Short and over-full frames:
  - 22 blocks then tag -> frame_error_o = 1; bytes 176..183 = 00; still 200 bytes.
  - 24 blocks -> overflow_o = 1; the 24th block is absent from the output.
- Simultaneous events: 23rd cipher event in the same cycle as end_tag event -> block 22 captured, frame_error_o = 0, SEND entered the next cycle.
- Reset mid-SEND at byte_cnt = 50 -> all outputs 0 the next cycle. A subsequent start_i runs a clean frame, and the sticky flags from the aborted frame are cleared.
